mem_port_arb: RTL and testbench
===============================

Name: mem_port_arb

Overview:
- N-port front-end that shares one line-granular memory controller among several clients (rasteriser, texture fetch, command processor, display).
- Each client has a valid/ready request channel and a response pulse.
- Arbitration is round-robin or fixed-priority; at most one transaction is in flight downstream.
- Sits between client blocks and the memory controller's data_ready / r_valid / w_valid interface.

Parameters:
- num_ports, 4, number of client ports (1..16).
- addr_width, 32, byte-address width.
- line_width, 64, data width of one request/response.
- arb_mode, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous assert, active-low.
- req_valid_i  in  num_ports  per-port request valid.
- req_ready_o  out  num_ports  per-port accept; one-hot or zero.
- req_write_i  in  num_ports  per-port 1 = write, 0 = read.
- req_addr_i  in  num_ports x addr_width  per-port byte address.
- req_data_i  in  num_ports x line_width  per-port write data.
- rsp_valid_o  out  num_ports  one-cycle completion pulse; one-hot or zero.
- rsp_data_o  out  line_width  read data, shared by all ports; valid with rsp_valid_o.
- busy_o  out  1  transaction captured or in flight.
- grant_id_o  out  clog2(num_ports) (min 1)  port currently owning the transaction.
- mem_data_ready_i  in  1  downstream idle and accepting.
- mem_r_valid_o  out  1  downstream read issue, one cycle.
- mem_w_valid_o  out  1  downstream write issue, one cycle.
- mem_addr_o  out  addr_width  downstream address.
- mem_write_o  out  line_width  downstream write data.
- mem_r_valid_i  in  1  downstream read data valid.
- mem_read_i  in  line_width  downstream read data.

Behaviour:
- Reset values:
  - state IDLE; all outputs 0.
  - rr pointer = num_ports-1, so port 0 has first priority.
  - captured addr/data = 0.
- States:
  - IDLE: req_ready_o[g] = 1 combinationally for winner g among req_valid_i. The handshake completes that cycle; addr/data/write/g are registered at the edge; next state ISSUE. If no request is valid, stay in IDLE.
  - ISSUE: wait until mem_data_ready_i = 1, then drive mem_r_valid_o or mem_w_valid_o high for exactly that cycle, with mem_addr_o/mem_write_o from the registers; next state BUSY. mem_addr_o/mem_write_o stay stable from ISSUE until leaving BUSY.
  - BUSY, read: complete on the first cycle with mem_r_valid_i = 1. rsp_data_o <= mem_read_i and rsp_valid_o[g] <= 1, both registered, visible the next cycle, one cycle wide.
  - BUSY, write: complete on the first cycle with mem_data_ready_i = 1, which can be no earlier than the cycle after issue. rsp_valid_o[g] pulses likewise; rsp_data_o holds its previous value.
  - On completion, next state IDLE. One bubble cycle between completion and the next grant. The IDLE of the response cycle may grant.
- Round-robin: search begins at pointer+1 mod num_ports. The pointer updates to g on each handshake.
- Fixed priority: lowest valid index wins; starvation is permitted.
- busy_o = state != IDLE. grant_id_o holds g from the handshake through completion.
- Protocol rules (bench asserts, RTL need not tolerate violations):
  - req_valid_i must hold until ready.
  - Request fields must be stable while valid.
- mem_r_valid_i in IDLE or ISSUE is ignored. A read completion observed while a write is outstanding is ignored.
- A reset mid-transaction discards it: no response, FSM to IDLE. A late mem_r_valid_i after reset is ignored.
- num_ports = 1: arbiter degenerates to pass-through; grant_id_o is constantly 0.
- Latency, zero downstream wait: handshake t, issue t+1, earliest read rsp_valid_o = t + 2 + downstream read latency.

Decomposition:
- Package mem_arb_pkg:
  - mem_arb_state_e {IDLE, ISSUE, BUSY}
  - mem_arb_mode_e {ARB_RR, ARB_FIXED}
  - grant index width function
- Sub-module rr_arbiter: parameters num_ports and mode; inputs req vector and pointer; outputs one-hot grant and index; purely combinational. The pointer register lives in mem_port_arb.

Test Plan:
- Single read, port 2, addr 0x40; downstream returns 0xDEADBEEF_CAFEF00D after 5 cycles -> req_ready_o = 0b0100 for one cycle; one mem_r_valid_o with mem_addr_o = 0x40; rsp_valid_o = 0b0100 with that data exactly 1 cycle after mem_r_valid_i.
- All 4 ports request continuously, arb_mode = 0 -> grant order 0,1,2,3,0,1; each port gets exactly 1 of every 4 responses.
- Same stimulus, arb_mode = 1 -> port 0 wins every arbitration; ports 1-3 are never granted while port 0 stays valid.
- Write, port 1, addr 0x80, data 0x1122334455667788; mem_data_ready_i held low for 10 cycles after issue -> mem_w_valid_o pulses once with correct addr/data; rsp_valid_o[1] occurs 1 cycle after mem_data_ready_i rises; no second issue.
- Downstream not ready at grant (mem_data_ready_i = 0 for 3 cycles) -> FSM stays in ISSUE; mem_r_valid_o rises only in the first cycle mem_data_ready_i = 1; busy_o stays high throughout.
- rst_ni asserted while in BUSY on a read, then mem_r_valid_i pulses -> no rsp_valid_o; outputs 0; rr pointer reset; the next request from port 0 is granted first.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and helpers for the memory port arbiter.
// Imported by mem_port_arb and rr_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY
    } mem_arb_state_e;

    typedef enum logic {
        ARB_RR,
        ARB_FIXED
    } mem_arb_mode_e;

    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin / fixed-priority request picker.
// The round-robin pointer is owned by the caller.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int            num_ports = 4,
    parameter mem_arb_mode_e mode      = ARB_RR,
    localparam int           gw        = grant_w(num_ports)
) (
    input  logic [num_ports-1:0] req_i,
    input  logic [gw-1:0]        ptr_i,
    output logic [num_ports-1:0] gnt_o,
    output logic [gw-1:0]        idx_o
);

    logic [gw-1:0] k;
    logic          found;

    // Round-robin scans from the port after the last winner.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 0; i < num_ports; i++) begin
            if (mode == ARB_FIXED) begin
                k = gw'(i);
            end else begin
                k = gw'((int'(ptr_i) + 1 + i) % num_ports);
            end
            if (!found && req_i[k]) begin
                found    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = k;
            end
        end
    end

endmodule

// File: rtl/mem_port_arb.sv
// mem_port_arb: shares one line-granular memory controller among N clients,
// one transaction in flight, with registered one-cycle completion pulses.
module mem_port_arb
    import mem_arb_pkg::*;
#(
    parameter int  num_ports  = 4,
    parameter int  addr_width = 32,
    parameter int  line_width = 64,
    parameter int  arb_mode   = 0,
    localparam int gw         = grant_w(num_ports)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [num_ports-1:0]            req_valid_i,
    output logic [num_ports-1:0]            req_ready_o,
    input  logic [num_ports-1:0]            req_write_i,
    input  logic [num_ports*addr_width-1:0] req_addr_i,
    input  logic [num_ports*line_width-1:0] req_data_i,
    output logic [num_ports-1:0]            rsp_valid_o,
    output logic [line_width-1:0]           rsp_data_o,
    output logic                            busy_o,
    output logic [gw-1:0]                   grant_id_o,
    input  logic                            mem_data_ready_i,
    output logic                            mem_r_valid_o,
    output logic                            mem_w_valid_o,
    output logic [addr_width-1:0]           mem_addr_o,
    output logic [line_width-1:0]           mem_write_o,
    input  logic                            mem_r_valid_i,
    input  logic [line_width-1:0]           mem_read_i
);

    mem_arb_state_e        state_q, state_d;
    logic [gw-1:0]         ptr_q, ptr_d;
    logic [gw-1:0]         gid_q, gid_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic [line_width-1:0] data_q, data_d;
    logic [line_width-1:0] rdata_q, rdata_d;
    logic                  wr_q, wr_d;
    logic [num_ports-1:0]  rsp_q, rsp_d;
    logic [num_ports-1:0]  gnt;
    logic [gw-1:0]         gnt_idx;
    logic                  issue;
    logic                  done;

    rr_arbiter #(
        .num_ports (num_ports),
        .mode      ((arb_mode == 1) ? ARB_FIXED : ARB_RR)
    ) u_arb (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        rsp_d   = '0;
        issue   = (state_q == ISSUE) && mem_data_ready_i;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|gnt) begin
                    state_d = ISSUE;
                    ptr_d   = gnt_idx;
                    gid_d   = gnt_idx;
                    for (int i = 0; i < num_ports; i++) begin
                        if (gnt[i]) begin
                            addr_d = req_addr_i[i*addr_width +: addr_width];
                            data_d = req_data_i[i*line_width +: line_width];
                            wr_d   = req_write_i[i];
                        end
                    end
                end
            end
            ISSUE: begin
                if (issue) state_d = BUSY;
            end
            BUSY: begin
                // Writes finish on the controller going idle; reads on data.
                done = wr_q ? mem_data_ready_i : mem_r_valid_i;
                if (done) begin
                    state_d      = IDLE;
                    rsp_d[gid_q] = 1'b1;
                    if (!wr_q) rdata_d = mem_read_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= gw'(num_ports - 1);
            gid_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            rsp_q   <= rsp_d;
        end
    end

    assign req_ready_o   = (state_q == IDLE) ? gnt : '0;
    assign mem_r_valid_o = issue && !wr_q;
    assign mem_w_valid_o = issue && wr_q;
    assign mem_addr_o    = addr_q;
    assign mem_write_o   = data_q;
    assign rsp_valid_o   = rsp_q;
    assign rsp_data_o    = rdata_q;
    assign busy_o        = (state_q != IDLE);
    assign grant_id_o    = gid_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: directed scenarios plus randomized traffic checked
// against a transaction-level arbitration model.
module tb_mem_port_arb;

    localparam int NP = 4;
    localparam int AW = 32;
    localparam int LW = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NP-1:0]   v_rr, v_fx, wr;
    logic [AW-1:0]   addr_a [NP];
    logic [LW-1:0]   data_a [NP];
    logic [NP*AW-1:0] addr_v;
    logic [NP*LW-1:0] data_v;
    logic            mrdy, mrv;
    logic [LW-1:0]   mrd;

    logic [NP-1:0] rdy_rr, rsp_rr, rdy_fx, rsp_fx;
    logic [LW-1:0] rdata_rr, rdata_fx, mwd_rr, mwd_fx;
    logic [AW-1:0] maddr_rr, maddr_fx;
    logic [1:0]    gid_rr, gid_fx;
    logic          busy_rr, busy_fx;
    logic          mrvo_rr, mwvo_rr, mrvo_fx, mwvo_fx;

    int          total = 0;
    int          bad = 0;
    logic [63:0] last_rd;
    int          ptr_m;
    bit          pend [NP];

    always #5 clk = ~clk;

    for (genvar i = 0; i < NP; i++) begin : g_pack
        assign addr_v[i*AW +: AW] = addr_a[i];
        assign data_v[i*LW +: LW] = data_a[i];
    end

    mem_port_arb #(
        .num_ports(NP), .addr_width(AW), .line_width(LW), .arb_mode(0)
    ) u_rr (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(v_rr), .req_ready_o(rdy_rr), .req_write_i(wr),
        .req_addr_i(addr_v), .req_data_i(data_v),
        .rsp_valid_o(rsp_rr), .rsp_data_o(rdata_rr),
        .busy_o(busy_rr), .grant_id_o(gid_rr),
        .mem_data_ready_i(mrdy), .mem_r_valid_o(mrvo_rr),
        .mem_w_valid_o(mwvo_rr), .mem_addr_o(maddr_rr),
        .mem_write_o(mwd_rr), .mem_r_valid_i(mrv), .mem_read_i(mrd)
    );

    mem_port_arb #(
        .num_ports(NP), .addr_width(AW), .line_width(LW), .arb_mode(1)
    ) u_fx (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(v_fx), .req_ready_o(rdy_fx), .req_write_i(wr),
        .req_addr_i(addr_v), .req_data_i(data_v),
        .rsp_valid_o(rsp_fx), .rsp_data_o(rdata_fx),
        .busy_o(busy_fx), .grant_id_o(gid_fx),
        .mem_data_ready_i(mrdy), .mem_r_valid_o(mrvo_fx),
        .mem_w_valid_o(mwvo_fx), .mem_addr_o(maddr_fx),
        .mem_write_o(mwd_fx), .mem_r_valid_i(mrv), .mem_read_i(mrd)
    );

    function automatic logic [63:0] onehot(input int p);
        return 64'(1) << p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction on the round-robin DUT: grant g, issue after rdy_dly
    // stalled cycles, complete lat cycles after issue. fg >= 0 also checks
    // the fixed-priority DUT running in lockstep.
    task automatic serve(input int g, input int fg, input bit keep,
                         input int rdy_dly, input int lat,
                         input logic [63:0] rd);
        int          n;
        bit          w;
        logic [31:0] a;
        logic [63:0] d;
        mrv = 1'b0;
        #1;
        n = 0;
        while (rdy_rr == '0 && n < 30) begin
            @(negedge clk);
            mrv = 1'b0;
            #1;
            n++;
        end
        chk("ready", rdy_rr, onehot(g));
        if (fg >= 0) chk("fx_ready", rdy_fx, onehot(fg));
        w = wr[g];
        a = addr_a[g];
        d = data_a[g];
        @(negedge clk);
        if (!keep) v_rr[g] = 1'b0;
        for (int i = 0; i <= rdy_dly; i++) begin
            mrdy = (i == rdy_dly);
            mrv  = 1'b1;
            mrd  = ~rd;
            #1;
            chk("busy_issue", busy_rr, 1);
            chk("gid_issue", gid_rr, g);
            chk("rsp_quiet_issue", rsp_rr, 0);
            chk("addr_issue", maddr_rr, a);
            chk("wdata_issue", mwd_rr, d);
            chk("r_issue", mrvo_rr, (i == rdy_dly) && !w);
            chk("w_issue", mwvo_rr, (i == rdy_dly) && w);
            @(negedge clk);
        end
        for (int i = 1; i <= lat; i++) begin
            mrdy = w && (i == lat);
            mrv  = w ? (i == 1) : (i == lat);
            mrd  = (!w && i == lat) ? rd : ~rd;
            #1;
            chk("busy_wait", busy_rr, 1);
            chk("gid_wait", gid_rr, g);
            chk("rsp_quiet_wait", rsp_rr, 0);
            chk("no_reissue", {mrvo_rr, mwvo_rr}, 0);
            chk("addr_hold", maddr_rr, a);
            @(negedge clk);
        end
        mrv  = 1'b0;
        mrdy = 1'b0;
        #1;
        chk("rsp", rsp_rr, onehot(g));
        if (!w) last_rd = rd;
        chk("rdata", rdata_rr, last_rd);
        chk("idle_after", busy_rr, 0);
        if (fg >= 0) chk("fx_rsp", rsp_fx, onehot(fg));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        v_rr = '0; v_fx = '0; wr = '0;
        mrdy = 1'b0; mrv = 1'b0; mrd = '0; last_rd = '0;
        for (int i = 0; i < NP; i++) begin
            addr_a[i] = '0;
            data_a[i] = '0;
        end
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", rdy_rr, 0);
        chk("rst_rsp", rsp_rr, 0);
        chk("rst_busy", busy_rr, 0);
        chk("rst_gid", gid_rr, 0);
        chk("rst_addr", maddr_rr, 0);
        chk("rst_wdata", mwd_rr, 0);
        chk("rst_issue", {mrvo_rr, mwvo_rr}, 0);
        chk("rst_rdata", rdata_rr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        addr_a[2] = 32'h40;
        wr[2]     = 1'b0;
        v_rr[2]   = 1'b1;
        serve(2, -1, 0, 0, 5, 64'hDEADBEEF_CAFEF00D);

        addr_a[1] = 32'h80;
        data_a[1] = 64'h1122334455667788;
        wr[1]     = 1'b1;
        v_rr[1]   = 1'b1;
        serve(1, -1, 0, 0, 11, 64'h0);

        addr_a[3] = 32'hC0;
        wr[3]     = 1'b0;
        v_rr[3]   = 1'b1;
        serve(3, -1, 0, 3, 2, 64'h0123_4567_89AB_CDEF);
        ptr_m = 3;

        for (int i = 0; i < NP; i++) begin
            addr_a[i] = 32'h1000 + 32'(i) * 32'h40;
            data_a[i] = {32'(i), 32'hA5A5_0000};
        end
        wr   = '0;
        v_rr = '1;
        v_fx = '1;
        for (int k = 0; k < 8; k++) begin
            g = (ptr_m + 1) % NP;
            serve(g, 0, 1, k % 2, 1 + k % 3, {$urandom, $urandom});
            ptr_m = g;
        end

        @(negedge clk);
        v_rr = '0;
        v_fx = '0;
        mrdy = 1'b1;
        @(negedge clk);
        mrdy = 1'b0;
        #1;
        chk("busy_before_rst", busy_rr, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {busy_rr, busy_fx}, 0);
        chk("mid_rst_rsp", {rsp_rr, rsp_fx}, 0);
        chk("mid_rst_gid", gid_rr, 0);
        chk("mid_rst_addr", maddr_rr, 0);
        chk("mid_rst_rdata", rdata_rr, 0);
        chk("mid_rst_issue", {mrvo_rr, mwvo_rr, mrvo_fx, mwvo_fx}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mrv   = 1'b1;
        mrd   = 64'hBAD0_BAD0_BAD0_BAD0;
        #1;
        chk("late_rv_rsp", {rsp_rr, rsp_fx}, 0);
        @(negedge clk);
        mrv = 1'b0;
        #1;
        chk("late_rv_rsp2", {rsp_rr, rsp_fx}, 0);
        chk("late_rv_rdata", rdata_rr, 0);
        chk("late_rv_busy", busy_rr, 0);
        last_rd = '0;

        wr[0] = 1'b0;
        wr[3] = 1'b0;
        v_rr  = 4'b1001;
        serve(0, -1, 0, 0, 1, 64'h5555_AAAA_5555_AAAA);
        ptr_m = 0;
        for (int i = 0; i < NP; i++) pend[i] = v_rr[i];

        for (int t = 0; t < 40; t++) begin
            bit any;
            any = 1'b0;
            for (int p = 0; p < NP; p++) begin
                if (!pend[p] && ($urandom_range(0, 1) == 1 || p == t % NP)) begin
                    addr_a[p] = $urandom;
                    data_a[p] = {$urandom, $urandom};
                    wr[p]     = 1'($urandom_range(0, 1));
                    pend[p]   = 1'b1;
                    v_rr[p]   = 1'b1;
                end
                any |= pend[p];
            end
            g = -1;
            for (int k = 1; k <= NP; k++) begin
                if (g < 0 && pend[(ptr_m + k) % NP]) g = (ptr_m + k) % NP;
            end
            if (any && g >= 0) begin
                serve(g, -1, 0, $urandom_range(0, 3), $urandom_range(1, 6),
                      {$urandom, $urandom});
                pend[g] = 1'b0;
                ptr_m   = g;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
